// File: rtl/loader_pkg.sv
// Shared state encoding and address constants for the program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_WRITE   = 3'd2,
    ST_CHECK   = 3'd3,
    ST_DONE    = 3'd4
  } loader_state_t;

  localparam logic [31:0] TEXT_BASE      = 32'h0040_0000;
  localparam int          BYTES_PER_WORD = 4;

  // Word index to byte address; wraps in 32 bits like the CPU's own adder.
  function automatic logic [31:0] word_address(input logic [31:0] base,
                                               input logic [5:0]  idx);
    return base + {24'd0, idx, 2'b00};
  endfunction

  function automatic logic [7:0] checksum_add(input logic [7:0] acc,
                                              input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/byte_assembler.sv
// Big-endian byte-to-word shift register: first byte lands in bits 31:24.
module byte_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_load,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_next_word,
  output logic        o_word_done
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [31:0] r_shift;
  logic [1:0]  r_count;

  // Word including the byte being accepted this cycle, so the FSM can
  // register it straight into the write port on the final transfer.
  assign o_next_word = {r_shift[23:0], i_byte};
  assign o_word_done = i_load && (r_count == LAST_BYTE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_shift <= o_next_word;
      r_count <= r_count + 2'd1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads a byte-streamed program image into instruction RAM and holds the CPU
// in reset until done. Optional trailing checksum byte: LOADER_CHECKSUM_EN.
module program_loader
  import loader_pkg::*;
#(
  parameter int          MEMORY_DEPTH = 32,
  parameter int          DATA_WIDTH   = 32,
  parameter logic [31:0] BASE_ADDRESS = TEXT_BASE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [5:0]            length_i,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  output logic                  mem_write_o,
  output logic [31:0]           mem_address_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic                  checksum_error_o,
  output logic                  cpu_reset_n_o
);

  loader_state_t          r_state;
  logic [5:0]             r_length;
  logic [5:0]             r_word_count;
  logic                   r_ready;
  logic                   r_write;
  logic [31:0]            r_mem_addr;
  logic [DATA_WIDTH-1:0]  r_mem_data;
  logic                   r_done;
  logic                   r_error;
  logic                   r_cpu_rst_n;
  logic                   r_cks_err;

  logic        w_xfer;
  logic        w_len_ok;
  logic        w_accept;
  logic        w_asm_load;
  logic        w_word_done;
  logic [31:0] w_next_word;

  assign w_xfer     = byte_valid_i && r_ready;
  assign w_len_ok   = (length_i != 6'd0) && (int'(length_i) <= MEMORY_DEPTH);
  assign w_accept   = (r_state == ST_IDLE) && start_i && w_len_ok;
  assign w_asm_load = w_xfer && (r_state == ST_COLLECT);

  byte_assembler u_asm (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_accept),
    .i_load      (w_asm_load),
    .i_byte      (byte_i),
    .o_next_word (w_next_word),
    .o_word_done (w_word_done)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_sum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sum <= '0;
    end else if (w_accept) begin
      r_sum <= '0;
    end else if (w_asm_load) begin
      r_sum <= checksum_add(r_sum, byte_i);
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_length     <= '0;
      r_word_count <= '0;
      r_ready      <= 1'b0;
      r_write      <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_cpu_rst_n  <= 1'b0;
      r_cks_err    <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_write <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            if (w_len_ok) begin
              r_length     <= length_i;
              r_word_count <= '0;
              r_cpu_rst_n  <= 1'b0;
              r_cks_err    <= 1'b0;
              r_ready      <= 1'b1;
              r_state      <= ST_COLLECT;
            end else begin
              r_error <= 1'b1;
            end
          end
        end
        ST_COLLECT: begin
          if (w_word_done) begin
            r_ready    <= 1'b0;
            r_write    <= 1'b1;
            r_mem_addr <= word_address(BASE_ADDRESS, r_word_count);
            r_mem_data <= w_next_word;
            r_state    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (r_word_count == r_length - 6'd1) begin
`ifdef LOADER_CHECKSUM_EN
            r_ready <= 1'b1;
            r_state <= ST_CHECK;
`else
            r_done  <= 1'b1;
            r_state <= ST_DONE;
`endif
          end else begin
            r_word_count <= r_word_count + 6'd1;
            r_ready      <= 1'b1;
            r_state      <= ST_COLLECT;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (w_xfer) begin
            if (checksum_add(r_sum, byte_i) != 8'h00) r_cks_err <= 1'b1;
            r_ready <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          // A failed checksum keeps the CPU parked until the next good load.
          r_cpu_rst_n <= ~r_cks_err;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign byte_ready_o  = r_ready;
  assign mem_write_o   = r_write;
  assign mem_address_o = r_mem_addr;
  assign mem_data_o    = r_mem_data;
  assign busy_o        = (r_state != ST_IDLE);
  assign done_o        = r_done;
  assign error_o       = r_error;
  assign cpu_reset_n_o = r_cpu_rst_n;
`ifdef LOADER_CHECKSUM_EN
  assign checksum_error_o = r_cks_err;
`else
  assign checksum_error_o = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed, table-driven bench for program_loader.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_i = 1'b0;
  logic [5:0]  length_i = '0;
  logic [7:0]  byte_i = '0;
  logic        byte_valid_i = 1'b0;
  logic        byte_ready_o;
  logic        mem_write_o;
  logic [31:0] mem_address_o;
  logic [31:0] mem_data_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic        checksum_error_o;
  logic        cpu_reset_n_o;

  program_loader dut (
    .clk              (clk),
    .reset            (reset),
    .start_i          (start_i),
    .length_i         (length_i),
    .byte_i           (byte_i),
    .byte_valid_i     (byte_valid_i),
    .byte_ready_o     (byte_ready_o),
    .mem_write_o      (mem_write_o),
    .mem_address_o    (mem_address_o),
    .mem_data_o       (mem_data_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .error_o          (error_o),
    .checksum_error_o (checksum_error_o),
    .cpu_reset_n_o    (cpu_reset_n_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int last_done_cyc = 0;
  int last_wr_cyc = 0;
  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  logic [7:0]  tb_sum = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_write_o) begin
      wq_addr.push_back(mem_address_o);
      wq_data.push_back(mem_data_o);
      last_wr_cyc = cyc;
    end
    if (done_o) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (error_o) err_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [5:0] len);
    @(negedge clk);
    start_i  = 1'b1;
    length_i = len;
    tb_sum   = '0;
    @(negedge clk);
    start_i  = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_i = b;
    byte_valid_i = 1'b1;
    while (!byte_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready_o) chk("ready_timeout", 32'd0, 32'd1);
    tb_sum = tb_sum + b;
    @(negedge clk);
    byte_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_done();
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (done_cnt == d0) chk("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    #1;
  endtask

  task automatic finish_load();
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00 - tb_sum);
`endif
    wait_done();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'd0, byte_ready_o}, 32'd0);
    chk({tag, "_write"}, {31'd0, mem_write_o}, 32'd0);
    chk({tag, "_addr"},  mem_address_o, 32'd0);
    chk({tag, "_data"},  mem_data_o, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy_o}, 32'd0);
    chk({tag, "_done"},  {31'd0, done_o}, 32'd0);
    chk({tag, "_err"},   {31'd0, error_o}, 32'd0);
    chk({tag, "_cks"},   {31'd0, checksum_error_o}, 32'd0);
    chk({tag, "_cpurst"}, {31'd0, cpu_reset_n_o}, 32'd0);
  endtask

  typedef struct {
    logic [5:0] len;
  } rej_vec_t;

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] exp_data;
  } word_vec_t;

  initial begin
    rej_vec_t  rej[3];
    word_vec_t wv[4];
    int wq0, d0, e0;

    rej[0] = '{len: 6'd0};
    rej[1] = '{len: 6'd33};
    rej[2] = '{len: 6'd63};
    wv[0] = '{b0: 8'h01, b1: 8'h02, b2: 8'h03, b3: 8'h04, exp_data: 32'h01020304};
    wv[1] = '{b0: 8'hFF, b1: 8'h00, b2: 8'hFF, b3: 8'h00, exp_data: 32'hFF00FF00};
    wv[2] = '{b0: 8'h00, b1: 8'h00, b2: 8'h00, b3: 8'h00, exp_data: 32'h00000000};
    wv[3] = '{b0: 8'h80, b1: 8'h7F, b2: 8'h01, b3: 8'hFE, exp_data: 32'h807F01FE};

    #12;
    check_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b1;

    // Two-word load from the example image
    do_start(6'd2);
    chk("load2_busy", {31'd0, busy_o}, 32'd1);
    chk("load2_cpurst_low", {31'd0, cpu_reset_n_o}, 32'd0);
    chk("load2_ready", {31'd0, byte_ready_o}, 32'd1);
    send_word(32'h20080005);
    send_word(32'h0000000C);
    finish_load();
    chk("load2_nwr", wq_addr.size(), 32'd2);
    if (wq_addr.size() == 2) begin
      chk("load2_a0", wq_addr[0], 32'h00400000);
      chk("load2_d0", wq_data[0], 32'h20080005);
      chk("load2_a1", wq_addr[1], 32'h00400004);
      chk("load2_d1", wq_data[1], 32'h0000000C);
    end
    chk("load2_done_cnt", done_cnt, 32'd1);
`ifndef LOADER_CHECKSUM_EN
    chk("load2_done_latency", last_done_cyc, last_wr_cyc + 1);
`endif
    chk("load2_cpurst_high", {31'd0, cpu_reset_n_o}, 32'd1);
    chk("load2_idle", {31'd0, busy_o}, 32'd0);
    chk("load2_hold_addr", mem_address_o, 32'h00400004);
    chk("load2_cks", {31'd0, checksum_error_o}, 32'd0);

    // Rejected starts
    wq0 = wq_addr.size();
    e0  = err_cnt;
    for (int i = 0; i < 3; i++) begin
      do_start(rej[i].len);
      chk($sformatf("rej%0d_error", i), {31'd0, error_o}, 32'd1);
      chk($sformatf("rej%0d_busy", i), {31'd0, busy_o}, 32'd0);
      @(negedge clk);
      chk($sformatf("rej%0d_pulse", i), {31'd0, error_o}, 32'd0);
    end
    chk("rej_err_cnt", err_cnt - e0, 32'd3);
    chk("rej_nowrite", wq_addr.size() - wq0, 32'd0);
    chk("rej_cpurst_kept", {31'd0, cpu_reset_n_o}, 32'd1);

    // Table of one-word loads
    for (int i = 0; i < 4; i++) begin
      wq_addr.delete();
      wq_data.delete();
      do_start(6'd1);
      send_byte(wv[i].b0);
      send_byte(wv[i].b1);
      send_byte(wv[i].b2);
      send_byte(wv[i].b3);
      finish_load();
      chk($sformatf("w%0d_nwr", i), wq_addr.size(), 32'd1);
      if (wq_addr.size() == 1) begin
        chk($sformatf("w%0d_addr", i), wq_addr[0], 32'h00400000);
        chk($sformatf("w%0d_data", i), wq_data[0], wv[i].exp_data);
      end
    end

    // Stall of 3 cycles between bytes 2 and 3
    wq_addr.delete();
    wq_data.delete();
    do_start(6'd1);
    send_byte(8'hDE);
    send_byte(8'hAD);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall%0d_ready", i), {31'd0, byte_ready_o}, 32'd1);
      @(negedge clk);
    end
    send_byte(8'hBE);
    send_byte(8'hEF);
    finish_load();
    chk("stall_nwr", wq_addr.size(), 32'd1);
    if (wq_addr.size() == 1) chk("stall_data", wq_data[0], 32'hDEADBEEF);

    // Asynchronous reset after 6 bytes of a 3-word load
    do_start(6'd3);
    send_word(32'hA1A2A3A4);
    send_byte(8'hB1);
    send_byte(8'hB2);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    reset = 1'b1;
    wq_addr.delete();
    wq_data.delete();
    do_start(6'd1);
    send_word(32'h11223344);
    finish_load();
    chk("postrst_nwr", wq_addr.size(), 32'd1);
    if (wq_addr.size() == 1) begin
      chk("postrst_addr", wq_addr[0], 32'h00400000);
      chk("postrst_data", wq_data[0], 32'h11223344);
    end

    // start_i during COLLECT must not disturb the running load
    wq_addr.delete();
    wq_data.delete();
    d0 = done_cnt;
    do_start(6'd2);
    send_byte(8'h01);
    send_byte(8'h02);
    start_i  = 1'b1;
    length_i = 6'd1;
    @(negedge clk);
    start_i  = 1'b0;
    send_byte(8'h03);
    send_byte(8'h04);
    send_word(32'h05060708);
    finish_load();
    chk("ign_nwr", wq_addr.size(), 32'd2);
    if (wq_addr.size() == 2) begin
      chk("ign_a1", wq_addr[1], 32'h00400004);
      chk("ign_d1", wq_data[1], 32'h05060708);
    end
    chk("ign_done_cnt", done_cnt - d0, 32'd1);

    // Full-depth load: last word lands at the top of the store
    wq_addr.delete();
    wq_data.delete();
    do_start(6'd32);
    for (int i = 0; i < 32; i++) send_word({4{i[7:0]}});
    finish_load();
    chk("full_nwr", wq_addr.size(), 32'd32);
    if (wq_addr.size() == 32) begin
      chk("full_last_addr", wq_addr[31], 32'h0040007C);
      chk("full_last_data", wq_data[31], 32'h1F1F1F1F);
    end

`ifdef LOADER_CHECKSUM_EN
    do_start(6'd1);
    send_word(32'h01020304);
    send_byte(8'hF6);
    wait_done();
    chk("cks_ok_err", {31'd0, checksum_error_o}, 32'd0);
    chk("cks_ok_cpurst", {31'd0, cpu_reset_n_o}, 32'd1);
    do_start(6'd1);
    send_word(32'h01020304);
    send_byte(8'hF7);
    wait_done();
    chk("cks_bad_err", {31'd0, checksum_error_o}, 32'd1);
    chk("cks_bad_cpurst", {31'd0, cpu_reset_n_o}, 32'd0);
    do_start(6'd1);
    chk("cks_clear_on_start", {31'd0, checksum_error_o}, 32'd0);
    send_word(32'h01020304);
    send_byte(8'hF6);
    wait_done();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
